apb4_ram_slave: RTL and testbench
=================================

# apb4_ram_slave

Parametrised APB4 completer fronting an on-chip RAM, replacing the fixed 32-bit single-cycle slave in the verification DUT set. It adds:
- configurable data width and depth
- byte-lane write merging
- programmable wait states
- address-range, alignment and secure-region error reporting

It sits behind the single-master APB4 bus and is the target of the RAM UVM environment.

## Interface
- DATA_WIDTH, 32, bus and word width; 32 or 64 only
- ADDR_WIDTH, 32, PADDR width
- MEM_DEPTH, 1024, number of words; power of two
- WAIT_STATES, 0, access-phase cycles with PREADY low before completion; 0..15
- SECURE_WORDS, 0, word indices below this accept only secure accesses (PPROT[1]=0); 0 disables the check

Ports:
- PCLK  in  1  clock; all logic on rising edge
- PRESETn  in  1  asynchronous active-low reset
- PSEL  in  1  slave select
- PENABLE  in  1  access phase
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  ADDR_WIDTH  byte address
- PWDATA  in  DATA_WIDTH  write data
- PSTRB  in  DATA_WIDTH/8  write byte strobes
- PPROT  in  3  protection attributes; only bit 1 (non-secure) is used
- PRDATA  out  DATA_WIDTH  read data
- PREADY  out  1  transfer completion
- PSLVERR  out  1  transfer error, valid only with PREADY

## Operation
- FSM has two states: IDLE and ACCESS.
  - IDLE -> ACCESS when PSEL=1 and PENABLE=0 (setup cycle).
  - ACCESS -> IDLE on the completion cycle, or when PSEL drops (aborted; no memory change, no response).
- Setup edge captures PWRITE, PADDR, PWDATA and PSTRB.
- Access-phase values of those inputs are ignored.
- Setup edge also performs the following:
  - loads the wait counter with WAIT_STATES
  - registers the memory word at the captured index into the read buffer
  - registers the error flag
- Word index = PADDR >> log2(DATA_WIDTH/8).
- Error is set when any of these holds:
  - PADDR low bits are non-zero (unaligned)
  - index >= MEM_DEPTH
  - read with PSTRB != 0
  - index < SECURE_WORDS and PPROT[1]=1
- Write without error: at the completion edge, only the byte lanes with PSTRB[i]=1 are replaced; the other lanes keep their old contents.
- Write with PSTRB=0 is a legal no-op with PSLVERR=0.
- Error transfers never modify memory.
- PRDATA drives the read buffer during a read completion cycle without error; otherwise it drives 0.
- Memory contents are not reset and are undefined until written.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state IDLE, counter 0, buffers 0, error flag 0
  - PREADY=0, PSLVERR=0, PRDATA=0
- Reset asserted mid-transfer: the transfer is dropped and a pending write is discarded.
- PREADY = (state==ACCESS) & PSEL & PENABLE & (counter==0); it is a combinational decode of registered state and bus inputs.
- The counter decrements on each ACCESS cycle while it is non-zero.
- Transfer length = 2 + WAIT_STATES cycles (setup + access).
- PSLVERR = PREADY & error flag. It is 0 on every cycle without PREADY.
- After completion the FSM returns to IDLE. A back-to-back transfer starts with its own setup cycle on the next clock.
- A read immediately after a write to the same word returns the merged data, because the write commits before the next setup edge.

## Structure
- Package apb4_ram_pkg holds:
  - state enum (IDLE, ACCESS)
  - the allowed DATA_WIDTH values
  - function computing the byte-offset bit count
- The wait counter width is $clog2(WAIT_STATES+1), minimum 1, local to the top module.
- Sub-module apb4_ram_mem: single-port array with DATA_WIDTH/8 byte enables, a synchronous write, and a read port registered by the top module.
- Top module contains: FSM, counter, capture registers, error decode, output muxing.

## Test plan
All scenarios use DATA_WIDTH=32, MEM_DEPTH=1024, WAIT_STATES=2, SECURE_WORDS=16.
- Full write then read: write 0xDEADBEEF to 0x100 with PSTRB=0xF, then read 0x100 -> PRDATA=0xDEADBEEF, PSLVERR=0, PREADY high on cycle 4 of each transfer.
- Strobe merge: 0x100 holds 0xDEADBEEF; write 0x11223344 with PSTRB=0x5, then read -> 0xDE22BE44.
- Error cases, each -> PSLVERR=1, PRDATA=0, and a following read of 0x100 returns its prior value:
  - unaligned write to 0x102
  - write to 0x1000 (index 1024)
  - read with PSTRB=0x1
- Secure region: write to 0x20 with PPROT=3'b010 -> PSLVERR=1. Same write with PPROT=3'b000 -> PSLVERR=0, and a read returns the written data.
- Abort and reset: deassert PSEL during a wait state -> PREADY stays 0 and memory is unchanged. Assert PRESETn=0 mid-access -> all outputs 0 immediately; the next transfer completes normally.

Source files
------------

// File: rtl/apb4_ram_pkg.sv
// apb4_ram_pkg
// Shared types and helpers for the APB4 RAM completer.
//   state_e        : two-state transfer FSM encoding (IDLE, ACCESS)
//   DW_NARROW/WIDE : the two supported bus/word widths
//   byte_off_bits  : number of PADDR low bits that select a byte within a word
package apb4_ram_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    localparam int DW_NARROW = 32;
    localparam int DW_WIDE   = 64;

    function automatic int byte_off_bits(input int data_width);
        return (data_width == DW_WIDE) ? 3 : 2;
    endfunction

endpackage

// File: rtl/apb4_ram_slave_if.sv
// apb4_ram_slave_if
// APB4 bus bundle between the single master and the RAM completer.
//   master modport : drives PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT;
//                    receives PRDATA, PREADY, PSLVERR
//   slave modport  : the mirror image
// Handshake: a transfer is a setup cycle (PSEL=1, PENABLE=0) followed by one or
// more access cycles (PSEL=1, PENABLE=1); it completes on the access cycle
// where PREADY=1, and PSLVERR/PRDATA are only meaningful on that cycle.
interface apb4_ram_slave_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    PSEL;
    logic                    PENABLE;
    logic                    PWRITE;
    logic [ADDR_WIDTH-1:0]   PADDR;
    logic [DATA_WIDTH-1:0]   PWDATA;
    logic [DATA_WIDTH/8-1:0] PSTRB;
    logic [2:0]              PPROT;
    logic [DATA_WIDTH-1:0]   PRDATA;
    logic                    PREADY;
    logic                    PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb4_ram_mem.sv
// apb4_ram_mem
// Single-port word array with per-byte write enables.
//   clk   : write clock
//   we    : write enable (synchronous)
//   be    : byte-lane enables, one per 8-bit lane
//   addr  : word index shared by read and write
//   wdata : write data
//   rdata : combinational read of the addressed word (registered by the parent)
// Contents are not reset.
module apb4_ram_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    localparam int MEM_AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1,
    localparam int NB        = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [NB-1:0]         be,
    input  logic [MEM_AW-1:0]     addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);
    import apb4_ram_pkg::*;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) begin
                    mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/apb4_ram_slave.sv
// apb4_ram_slave
// APB4 completer in front of an on-chip RAM with byte-lane merging,
// programmable wait states and error reporting.
//   PCLK      : clock, rising edge
//   PRESETn   : asynchronous active-low reset
//   apb       : APB4 bus (slave modport)
//   dbg_state : current FSM state, for observation only
// The setup cycle captures the whole request (address, data, strobes, error
// decode and the addressed RAM word); access-phase bus values are ignored.
module apb4_ram_slave
    import apb4_ram_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int MEM_DEPTH    = 1024,
    parameter int WAIT_STATES  = 0,
    parameter int SECURE_WORDS = 0
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    apb4_ram_slave_if.slave     apb,
    output state_e              dbg_state
);
    localparam int NB       = DATA_WIDTH / 8;
    localparam int OFF_BITS = byte_off_bits(DATA_WIDTH);
    localparam int MEM_AW   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int CNT_W    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic                  cap_write_q;
    logic [MEM_AW-1:0]     cap_idx_q;
    logic [DATA_WIDTH-1:0] cap_wdata_q;
    logic [NB-1:0]         cap_strb_q;
    logic [DATA_WIDTH-1:0] rd_buf_q;
    logic                  err_q;

    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  unaligned;
    logic                  out_of_range;
    logic                  bad_read_strb;
    logic                  secure_viol;
    logic                  err_d;
    logic                  setup;
    logic                  ready;
    logic                  mem_we;
    logic [MEM_AW-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  unused_prot;

    // ---------------- request decode ----------------
    assign word_idx      = apb.PADDR >> OFF_BITS;
    assign unaligned     = |apb.PADDR[OFF_BITS-1:0];
    assign out_of_range  = word_idx >= ADDR_WIDTH'(MEM_DEPTH);
    assign bad_read_strb = ~apb.PWRITE & (|apb.PSTRB);

    // Only PPROT[1] matters, and only when a secure region exists.
    generate
        if (SECURE_WORDS > 0) begin : g_secure
            assign secure_viol = (word_idx < ADDR_WIDTH'(SECURE_WORDS)) & apb.PPROT[1];
        end else begin : g_no_secure
            assign secure_viol = 1'b0;
        end
    endgenerate
    assign unused_prot = ^apb.PPROT;

    assign err_d = unaligned | out_of_range | bad_read_strb | secure_viol;

    // ---------------- handshake decode ----------------
    assign setup = (state_q == IDLE) & apb.PSEL & ~apb.PENABLE;
    assign ready = (state_q == ACCESS) & apb.PSEL & apb.PENABLE & (cnt_q == '0);

    // ---------------- FSM ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (setup) state_d = ACCESS;
            end
            ACCESS: begin
                // Either completion or PSEL dropping (abort) ends the transfer.
                if (!apb.PSEL || ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- counter and capture registers ----------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt_q       <= '0;
            cap_write_q <= 1'b0;
            cap_idx_q   <= '0;
            cap_wdata_q <= '0;
            cap_strb_q  <= '0;
            rd_buf_q    <= '0;
            err_q       <= 1'b0;
        end else if (setup) begin
            cnt_q       <= CNT_W'(WAIT_STATES);
            cap_write_q <= apb.PWRITE;
            cap_idx_q   <= word_idx[MEM_AW-1:0];
            cap_wdata_q <= apb.PWDATA;
            cap_strb_q  <= apb.PSTRB;
            rd_buf_q    <= mem_rdata;
            err_q       <= err_d;
        end else if ((state_q == ACCESS) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // ---------------- memory ----------------
    // The single port reads the live bus address during setup and uses the
    // captured index while a transfer is in flight (for the write commit).
    assign mem_addr = (state_q == ACCESS) ? cap_idx_q : word_idx[MEM_AW-1:0];
    assign mem_we   = ready & cap_write_q & ~err_q;

    apb4_ram_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_mem (
        .clk   (PCLK),
        .we    (mem_we),
        .be    (cap_strb_q),
        .addr  (mem_addr),
        .wdata (cap_wdata_q),
        .rdata (mem_rdata)
    );

    // ---------------- outputs ----------------
    assign apb.PREADY  = ready;
    assign apb.PSLVERR = ready & err_q;
    assign apb.PRDATA  = (ready & ~cap_write_q & ~err_q) ? rd_buf_q : '0;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_apb4_ram_slave.sv
module tb_apb4_ram_slave;
    import apb4_ram_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    apb4_ram_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    state_e dbg_state;

    apb4_ram_slave #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .MEM_DEPTH    (1024),
        .WAIT_STATES  (2),
        .SECURE_WORDS (16)
    ) dut (
        .PCLK      (clk),
        .PRESETn   (rst_n),
        .apb       (bus.slave),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] strb, input logic [2:0] prot,
                                input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb; v.prot = prot;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic bus_idle();
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        bus.PADDR = '0; bus.PWDATA = '0; bus.PSTRB = '0; bus.PPROT = '0;
    endtask

    task automatic drive_setup(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] strb, input logic [2:0] prot);
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr;
        bus.PADDR = addr; bus.PWDATA = wdata; bus.PSTRB = strb; bus.PPROT = prot;
    endtask

    // Called just after a rising edge. Returns just after the completion edge
    // with the bus idle, so the next call is a back-to-back transfer.
    // Access-phase address/data/strobes are scrambled: they must be ignored.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input logic [2:0] prot,
                            output logic [31:0] rdata, output logic err,
                            output int rdy_cyc, output int noisy);
        rdata = '0; err = 1'b0; rdy_cyc = 0; noisy = 0;
        drive_setup(wr, addr, wdata, strb, prot);
        @(posedge clk); #1;
        bus.PENABLE = 1'b1;
        bus.PADDR   = addr ^ 32'h10;
        bus.PWDATA  = ~wdata;
        bus.PSTRB   = ~strb;
        for (int c = 2; c <= 20; c++) begin
            @(negedge clk);
            if (bus.PREADY) begin
                rdy_cyc = c;
                rdata   = bus.PRDATA;
                err     = bus.PSLVERR;
                break;
            end
            if (bus.PSLVERR || bus.PRDATA != '0) noisy++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus_idle();
    endtask

    logic [31:0] rd;
    logic        er;
    int          cyc;
    int          noisy;
    int          bad;

    initial begin
        // Table: wr, addr, wdata, strb, prot, expected PRDATA, expected PSLVERR
        vecs.push_back(mk(1, 32'h100,  32'hDEADBEEF, 4'hF, 3'b000, 32'h0,        0));
        vecs.push_back(mk(0, 32'h100,  32'h0,        4'h0, 3'b000, 32'hDEADBEEF, 0));
        vecs.push_back(mk(1, 32'h100,  32'h11223344, 4'h5, 3'b000, 32'h0,        0));
        vecs.push_back(mk(0, 32'h100,  32'h0,        4'h0, 3'b000, 32'hDE22BE44, 0));
        vecs.push_back(mk(1, 32'h102,  32'hAAAAAAAA, 4'hF, 3'b000, 32'h0,        1));
        vecs.push_back(mk(0, 32'h100,  32'h0,        4'h0, 3'b000, 32'hDE22BE44, 0));
        vecs.push_back(mk(1, 32'h000,  32'h0F0F0F0F, 4'hF, 3'b000, 32'h0,        0));
        vecs.push_back(mk(1, 32'h1000, 32'hAAAAAAAA, 4'hF, 3'b000, 32'h0,        1));
        vecs.push_back(mk(0, 32'h100,  32'h0,        4'h0, 3'b000, 32'hDE22BE44, 0));
        vecs.push_back(mk(0, 32'h000,  32'h0,        4'h0, 3'b000, 32'h0F0F0F0F, 0));
        vecs.push_back(mk(0, 32'h100,  32'h0,        4'h1, 3'b000, 32'h0,        1));
        vecs.push_back(mk(0, 32'h100,  32'h0,        4'h0, 3'b000, 32'hDE22BE44, 0));
        vecs.push_back(mk(1, 32'h020,  32'hCAFEF00D, 4'hF, 3'b010, 32'h0,        1));
        vecs.push_back(mk(1, 32'h020,  32'hCAFEF00D, 4'hF, 3'b000, 32'h0,        0));
        vecs.push_back(mk(0, 32'h020,  32'h0,        4'h0, 3'b000, 32'hCAFEF00D, 0));
        vecs.push_back(mk(0, 32'h020,  32'h0,        4'h0, 3'b010, 32'h0,        1));
        vecs.push_back(mk(1, 32'h03C,  32'h13579BDF, 4'hF, 3'b010, 32'h0,        1));
        vecs.push_back(mk(1, 32'h040,  32'h2468ACE0, 4'hF, 3'b010, 32'h0,        0));
        vecs.push_back(mk(0, 32'h040,  32'h0,        4'h0, 3'b010, 32'h2468ACE0, 0));
        vecs.push_back(mk(1, 32'h104,  32'h55AA55AA, 4'hF, 3'b000, 32'h0,        0));
        vecs.push_back(mk(1, 32'h104,  32'hFFFFFFFF, 4'h0, 3'b000, 32'h0,        0));
        vecs.push_back(mk(0, 32'h104,  32'h0,        4'h0, 3'b000, 32'h55AA55AA, 0));
        vecs.push_back(mk(1, 32'hFFC,  32'h01020304, 4'hF, 3'b000, 32'h0,        0));
        vecs.push_back(mk(0, 32'hFFC,  32'h0,        4'h0, 3'b000, 32'h01020304, 0));
        vecs.push_back(mk(0, 32'h1000, 32'h0,        4'h0, 3'b000, 32'h0,        1));

        // ---------------- reset ----------------
        rst_n = 1'b0;
        bus_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_pready",  64'(bus.PREADY),  64'(0));
        check("reset_pslverr", 64'(bus.PSLVERR), 64'(0));
        check("reset_prdata",  64'(bus.PRDATA),  64'(0));
        check("reset_state",   64'(dbg_state),   64'(IDLE));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ---------------- table-driven vectors ----------------
        foreach (vecs[i]) begin
            apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].prot,
                     rd, er, cyc, noisy);
            check($sformatf("v%0d_ready_cycle", i), 64'(cyc),   64'(4));
            check($sformatf("v%0d_prdata", i),      64'(rd),    64'(vecs[i].exp_rdata));
            check($sformatf("v%0d_pslverr", i),     64'(er),    64'(vecs[i].exp_err));
            check($sformatf("v%0d_wait_quiet", i),  64'(noisy), 64'(0));
        end

        // ---------------- abort during a wait state ----------------
        drive_setup(1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, 3'b000);
        @(posedge clk); #1;
        bus.PENABLE = 1'b1;
        @(negedge clk);
        check("abort_wait_pready", 64'(bus.PREADY), 64'(0));
        @(posedge clk); #1;
        bus_idle();
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus.PREADY || bus.PSLVERR) bad++;
        end
        check("abort_no_response", 64'(bad),       64'(0));
        check("abort_state_idle",  64'(dbg_state), 64'(IDLE));
        @(posedge clk); #1;
        apb_xfer(1'b0, 32'h100, 32'h0, 4'h0, 3'b000, rd, er, cyc, noisy);
        check("abort_mem_kept", 64'(rd), 64'(32'hDE22BE44));
        check("abort_next_cyc", 64'(cyc), 64'(4));

        // ---------------- reset during a read completion ----------------
        drive_setup(1'b0, 32'h100, 32'h0, 4'h0, 3'b000);
        @(posedge clk); #1;
        bus.PENABLE = 1'b1;
        bad = 1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.PREADY) begin bad = 0; break; end
        end
        check("rst_rd_reached_ready", 64'(bad), 64'(0));
        check("rst_rd_prdata_before", 64'(bus.PRDATA), 64'(32'hDE22BE44));
        rst_n = 1'b0;
        #1;
        check("rst_rd_pready",  64'(bus.PREADY), 64'(0));
        check("rst_rd_prdata",  64'(bus.PRDATA), 64'(0));
        @(posedge clk); #1;
        bus_idle();
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ---------------- reset during a write completion ----------------
        drive_setup(1'b1, 32'h100, 32'h00000000, 4'hF, 3'b000);
        @(posedge clk); #1;
        bus.PENABLE = 1'b1;
        bad = 1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.PREADY) begin bad = 0; break; end
        end
        check("rst_wr_reached_ready", 64'(bad), 64'(0));
        rst_n = 1'b0;
        #1;
        check("rst_wr_pready",  64'(bus.PREADY),  64'(0));
        check("rst_wr_pslverr", 64'(bus.PSLVERR), 64'(0));
        check("rst_wr_prdata",  64'(bus.PRDATA),  64'(0));
        check("rst_wr_state",   64'(dbg_state),   64'(IDLE));
        @(posedge clk); #1;
        bus_idle();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        apb_xfer(1'b0, 32'h100, 32'h0, 4'h0, 3'b000, rd, er, cyc, noisy);
        check("rst_write_dropped", 64'(rd),  64'(32'hDE22BE44));
        check("rst_next_cyc",      64'(cyc), 64'(4));
        check("rst_next_err",      64'(er),  64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
